// File: rtl/ps2_cmd_sequencer_pkg.sv
// Shared constants for the PS/2 host command path: keyboard reply codes,
// host command opcodes, sequencer error codes and FSM state encodings.
package ps2_cmd_sequencer_pkg;

   localparam logic [7:0] SCAN_ACK      = 8'hFA;
   localparam logic [7:0] SCAN_RESEND   = 8'hFE;
   localparam logic [7:0] SCAN_BAT_OK   = 8'hAA;
   localparam logic [7:0] SCAN_BAT_FAIL = 8'hFC;
   localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
   localparam logic [7:0] CMD_RESET     = 8'hFF;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_RETRY   = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_BAT     = 2'd3
   } err_code_t;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_SEND_CMD  = 4'd1,
      ST_WAIT_TXC  = 4'd2,
      ST_WAIT_ACKC = 4'd3,
      ST_SEND_ARG  = 4'd4,
      ST_WAIT_TXA  = 4'd5,
      ST_WAIT_ACKA = 4'd6,
      ST_WAIT_BAT  = 4'd7,
      ST_DONE      = 4'd8,
      ST_ERR       = 4'd9
   } state_t;

endpackage

// File: rtl/ps2_cmd_sequencer_if.sv
// Request, transmitter, receiver and status signals of the PS/2 command sequencer.
// The sequencer uses the slave view; its surroundings (or a bench) use master.
interface ps2_cmd_sequencer_if;
   logic       req_valid;
   logic [7:0] req_cmd;
   logic       req_has_arg;
   logic [7:0] req_arg;
   logic       req_ready;
   logic       tx_start;
   logic [7:0] tx_byte;
   logic       tx_done;
   logic       rx_done;
   logic [7:0] rx_byte;
   logic       rx_fwd_done;
   logic       cmd_done;
   logic       cmd_err;
   logic [1:0] err_code;

   modport master (
      output req_valid, req_cmd, req_has_arg, req_arg, tx_done, rx_done, rx_byte,
      input  req_ready, tx_start, tx_byte, rx_fwd_done, cmd_done, cmd_err, err_code
   );

   modport slave (
      input  req_valid, req_cmd, req_has_arg, req_arg, tx_done, rx_done, rx_byte,
      output req_ready, tx_start, tx_byte, rx_fwd_done, cmd_done, cmd_err, err_code
   );
endinterface

// File: rtl/ps2_cmd_sequencer_counter.sv
// Free-running up counter with synchronous clear; clear has priority over increment.
module ps2_cmd_sequencer_counter #(
   parameter int W = 26
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Host-side PS/2 command sequencer: sends opcode (+ optional argument), consumes
// ACK/RESEND/BAT replies, retries on RESEND and times out on silence.
module ps2_cmd_sequencer
   import ps2_cmd_sequencer_pkg::*;
#(
   parameter int ACK_TIMEOUT = 1_000_000,
   parameter int BAT_TIMEOUT = 50_000_000,
   parameter int MAX_RETRIES = 3,
   parameter int TMR_W       = 26
) (
   input  logic               clk,
   input  logic               rst,
   ps2_cmd_sequencer_if.slave bus
);

   localparam int RTR_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   localparam logic [RTR_W-1:0] MAX_R   = RTR_W'(MAX_RETRIES);
   localparam logic [TMR_W-1:0] ACK_LIM = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] BAT_LIM = TMR_W'(BAT_TIMEOUT - 1);

   state_t           state, state_nxt;
   err_code_t        err_q, err_nxt;
   logic [RTR_W-1:0] retry_q;
   logic [TMR_W-1:0] tmr;
   logic [7:0]       tx_byte_q;
   logic [7:0]       cmd_q, arg_q;
   logic             has_arg_q;

   logic accept, ack_state, rx_ack, rx_resend, rx_bat_ok, rx_bat_fail;
   logic consumed, tmr_inc, tmr_exp;

   assign accept      = bus.req_valid && (state == ST_IDLE);
   assign ack_state   = (state == ST_WAIT_ACKC) || (state == ST_WAIT_ACKA);
   assign rx_ack      = bus.rx_done && (bus.rx_byte == SCAN_ACK);
   assign rx_resend   = bus.rx_done && (bus.rx_byte == SCAN_RESEND);
   assign rx_bat_ok   = bus.rx_done && (bus.rx_byte == SCAN_BAT_OK);
   assign rx_bat_fail = bus.rx_done && (bus.rx_byte == SCAN_BAT_FAIL);
   assign consumed    = (ack_state && (rx_ack || rx_resend)) ||
                        ((state == ST_WAIT_BAT) && (rx_bat_ok || rx_bat_fail));

   assign tmr_inc = state inside {ST_WAIT_TXC, ST_WAIT_ACKC, ST_WAIT_TXA,
                                  ST_WAIT_ACKA, ST_WAIT_BAT};
   assign tmr_exp = (state == ST_WAIT_BAT) ? (tmr == BAT_LIM) : (tmr == ACK_LIM);

   // Timer restarts from zero on every state change.
   ps2_cmd_sequencer_counter #(.W(TMR_W)) u_tmr (
      .clk (clk),
      .rst (rst),
      .clr (state_nxt != state),
      .inc (tmr_inc),
      .cnt (tmr)
   );

   always_comb begin
      state_nxt = state;
      err_nxt   = ERR_NONE;
      case (state)
         ST_IDLE:     if (bus.req_valid) state_nxt = ST_SEND_CMD;
         ST_SEND_CMD: state_nxt = ST_WAIT_TXC;
         ST_SEND_ARG: state_nxt = ST_WAIT_TXA;
         ST_WAIT_TXC, ST_WAIT_TXA: begin
            if (bus.tx_done) begin
               state_nxt = (state == ST_WAIT_TXC) ? ST_WAIT_ACKC : ST_WAIT_ACKA;
            end else if (tmr_exp) begin
               state_nxt = ST_ERR;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         ST_WAIT_ACKC, ST_WAIT_ACKA: begin
            if (rx_ack) begin
               if (state == ST_WAIT_ACKA)  state_nxt = ST_DONE;
               else if (has_arg_q)         state_nxt = ST_SEND_ARG;
               else if (cmd_q == CMD_RESET) state_nxt = ST_WAIT_BAT;
               else                        state_nxt = ST_DONE;
            end else if (rx_resend) begin
               if (retry_q < MAX_R) begin
                  state_nxt = (state == ST_WAIT_ACKC) ? ST_SEND_CMD : ST_SEND_ARG;
               end else begin
                  state_nxt = ST_ERR;
                  err_nxt   = ERR_RETRY;
               end
            end else if (tmr_exp) begin
               state_nxt = ST_ERR;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         ST_WAIT_BAT: begin
            if (rx_bat_ok) begin
               state_nxt = ST_DONE;
            end else if (rx_bat_fail) begin
               state_nxt = ST_ERR;
               err_nxt   = ERR_BAT;
            end else if (tmr_exp) begin
               state_nxt = ST_ERR;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         ST_DONE, ST_ERR: state_nxt = ST_IDLE;
         default:         state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         err_q     <= ERR_NONE;
         retry_q   <= '0;
         tx_byte_q <= 8'h00;
      end else begin
         state <= state_nxt;

         if (accept)                    err_q <= ERR_NONE;
         else if (state_nxt == ST_ERR)  err_q <= err_nxt;

         // Retries are counted per byte: the argument starts with a fresh budget.
         if (accept)
            retry_q <= '0;
         else if ((state == ST_WAIT_ACKC) && (state_nxt == ST_SEND_ARG))
            retry_q <= '0;
         else if (ack_state && rx_resend && (state_nxt != ST_ERR))
            retry_q <= retry_q + 1'b1;

         if (accept)                          tx_byte_q <= bus.req_cmd;
         else if ((state == ST_WAIT_ACKC) && (state_nxt == ST_SEND_ARG))
                                              tx_byte_q <= arg_q;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         cmd_q     <= bus.req_cmd;
         has_arg_q <= bus.req_has_arg;
         arg_q     <= bus.req_arg;
      end
   end

   assign bus.req_ready   = (state == ST_IDLE);
   assign bus.tx_start    = (state == ST_SEND_CMD) || (state == ST_SEND_ARG);
   assign bus.tx_byte     = tx_byte_q;
   assign bus.cmd_done    = (state == ST_DONE);
   assign bus.cmd_err     = (state == ST_ERR);
   assign bus.err_code    = err_q;
   assign bus.rx_fwd_done = bus.rx_done && !consumed;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer: command/argument flow, BAT handling,
// RESEND retries, timeouts, reply filtering and mid-command reset.
module tb_ps2_cmd_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ps2_cmd_sequencer_if bus();

   ps2_cmd_sequencer #(
      .ACK_TIMEOUT (20),
      .BAT_TIMEOUT (40),
      .MAX_RETRIES (3),
      .TMR_W       (26)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_errs = 0;

   // Pulse monitor, sampled on the falling edge.
   int         n_tx = 0, n_done = 0, n_err = 0, n_fwd = 0;
   logic [7:0] tx_log [64];

   always @(negedge clk) begin
      if (bus.tx_start) begin
         if (n_tx < 64) tx_log[n_tx] = bus.tx_byte;
         n_tx = n_tx + 1;
      end
      if (bus.cmd_done)    n_done = n_done + 1;
      if (bus.cmd_err)     n_err  = n_err + 1;
      if (bus.rx_fwd_done) n_fwd  = n_fwd + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic request(input logic [7:0] c, input logic has, input logic [7:0] a);
      bus.req_valid   = 1'b1;
      bus.req_cmd     = c;
      bus.req_has_arg = has;
      bus.req_arg     = a;
      cyc();
      bus.req_valid   = 1'b0;
   endtask

   task automatic pulse_txd();
      bus.tx_done = 1'b1;
      cyc();
      bus.tx_done = 1'b0;
   endtask

   task automatic reply(input logic [7:0] b);
      bus.rx_byte = b;
      bus.rx_done = 1'b1;
      cyc();
      bus.rx_done = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (bus.tx_start) seen = 1'b1;
         else cyc();
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   // Transmit one byte and answer it with a reply byte.
   task automatic xfer(input string tag, input logic [7:0] rep);
      wait_start(tag);
      cyc();
      pulse_txd();
      reply(rep);
   endtask

   int b_tx, b_done, b_err, b_fwd;

   task automatic snap();
      b_tx = n_tx; b_done = n_done; b_err = n_err; b_fwd = n_fwd;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0; bus.req_cmd = 8'h00; bus.req_has_arg = 1'b0;
      bus.req_arg   = 8'h00; bus.tx_done = 1'b0; bus.rx_done = 1'b0;
      bus.rx_byte   = 8'h00;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_ready",   32'(bus.req_ready), 32'd1);
      chk("rst_txstart", 32'(bus.tx_start),  32'd0);
      chk("rst_txbyte",  32'(bus.tx_byte),   32'h00);
      chk("rst_errcode", 32'(bus.err_code),  32'd0);
      rst = 1'b0;
      cyc();

      // 1: ED + 02, both ACKed
      snap();
      request(8'hED, 1'b1, 8'h02);
      chk("t1_acc_lat",  32'(bus.tx_start), 32'd1);
      chk("t1_byte_cmd", 32'(bus.tx_byte),  32'hED);
      cyc();
      pulse_txd();
      reply(8'hFA);
      chk("t1_fa_lat",   32'(bus.tx_start), 32'd1);
      chk("t1_byte_arg", 32'(bus.tx_byte),  32'h02);
      cyc();
      pulse_txd();
      reply(8'hFA);
      chk("t1_done_lat", 32'(bus.cmd_done), 32'd1);
      chk("t1_errcode",  32'(bus.err_code), 32'd0);
      cyc();
      chk("t1_ready",    32'(bus.req_ready), 32'd1);
      chk("t1_ntx",   n_tx - b_tx, 2);
      chk("t1_tx0",   32'(tx_log[b_tx]),     32'hED);
      chk("t1_tx1",   32'(tx_log[b_tx + 1]), 32'h02);
      chk("t1_ndone", n_done - b_done, 1);
      chk("t1_nerr",  n_err - b_err, 0);
      chk("t1_nfwd",  n_fwd - b_fwd, 0);

      // 2a: FF, ACK then BAT OK
      snap();
      request(8'hFF, 1'b0, 8'h00);
      xfer("t2a_start", 8'hFA);
      chk("t2a_wait_bat", 32'(bus.cmd_done), 32'd0);
      reply(8'hAA);
      chk("t2a_done", 32'(bus.cmd_done), 32'd1);
      cyc();
      chk("t2a_ntx", n_tx - b_tx, 1);

      // 2b: FF, ACK then BAT fail
      snap();
      request(8'hFF, 1'b0, 8'h00);
      xfer("t2b_start", 8'hFA);
      reply(8'hFC);
      chk("t2b_err",     32'(bus.cmd_err),  32'd1);
      chk("t2b_errcode", 32'(bus.err_code), 32'd3);
      cyc();
      chk("t2b_held",    32'(bus.err_code), 32'd3);
      chk("t2b_ndone",   n_done - b_done, 0);
      chk("t2b_nfwd",    n_fwd - b_fwd, 0);

      // 3a: three RESENDs on the opcode, then ACK, then argument
      snap();
      request(8'hED, 1'b1, 8'h55);
      chk("t3a_errclr", 32'(bus.err_code), 32'd0);
      for (int i = 0; i < 3; i++) xfer("t3a_resend", 8'hFE);
      xfer("t3a_cmd_ack", 8'hFA);
      xfer("t3a_arg_ack", 8'hFA);
      chk("t3a_done", 32'(bus.cmd_done), 32'd1);
      cyc();
      chk("t3a_ntx", n_tx - b_tx, 5);
      for (int i = 0; i < 4; i++) chk("t3a_txcmd", 32'(tx_log[b_tx + i]), 32'hED);
      chk("t3a_txarg", 32'(tx_log[b_tx + 4]), 32'h55);

      // 3b: fourth RESEND on the opcode exhausts retries
      snap();
      request(8'hED, 1'b1, 8'h55);
      for (int i = 0; i < 4; i++) xfer("t3b_resend", 8'hFE);
      chk("t3b_err",     32'(bus.cmd_err),  32'd1);
      chk("t3b_errcode", 32'(bus.err_code), 32'd1);
      cyc();
      chk("t3b_ntx", n_tx - b_tx, 4);

      // 4a: silence after tx_done -> timeout exactly 20 cycles into WAIT_ACKC
      snap();
      request(8'hED, 1'b0, 8'h00);
      wait_start("t4a_start");
      cyc();
      pulse_txd();
      repeat (19) cyc();
      chk("t4a_not_yet", 32'(bus.cmd_err), 32'd0);
      cyc();
      chk("t4a_err",     32'(bus.cmd_err),  32'd1);
      chk("t4a_errcode", 32'(bus.err_code), 32'd2);
      cyc();

      // 4b: ACK on the expiry cycle wins
      snap();
      request(8'hED, 1'b0, 8'h00);
      wait_start("t4b_start");
      cyc();
      pulse_txd();
      repeat (19) cyc();
      reply(8'hFA);
      chk("t4b_done", 32'(bus.cmd_done), 32'd1);
      chk("t4b_noerr", 32'(bus.cmd_err), 32'd0);
      cyc();
      chk("t4b_nerr", n_err - b_err, 0);

      // 5: unrelated scan code in WAIT_ACKC is forwarded, ACK still completes
      snap();
      request(8'hED, 1'b0, 8'h00);
      wait_start("t5_start");
      cyc();
      pulse_txd();
      bus.rx_byte = 8'h1C;
      bus.rx_done = 1'b1;
      #1;
      chk("t5_fwd", 32'(bus.rx_fwd_done), 32'd1);
      cyc();
      bus.rx_done = 1'b0;
      chk("t5_ready", 32'(bus.req_ready), 32'd0);
      chk("t5_nodone", 32'(bus.cmd_done), 32'd0);
      bus.rx_byte = 8'hFA;
      bus.rx_done = 1'b1;
      #1;
      chk("t5_ack_nofwd", 32'(bus.rx_fwd_done), 32'd0);
      cyc();
      bus.rx_done = 1'b0;
      chk("t5_done", 32'(bus.cmd_done), 32'd1);
      cyc();
      bus.rx_byte = 8'hFA;
      bus.rx_done = 1'b1;
      #1;
      chk("t5_idle_fwd", 32'(bus.rx_fwd_done), 32'd1);
      cyc();
      bus.rx_done = 1'b0;
      chk("t5_nfwd", n_fwd - b_fwd, 2);

      // 6: reset while waiting for the argument's tx_done
      snap();
      request(8'hED, 1'b1, 8'h33);
      xfer("t6_cmd", 8'hFA);
      wait_start("t6_arg");
      cyc();
      rst = 1'b1;
      #1;
      chk("t6_ready",   32'(bus.req_ready), 32'd1);
      chk("t6_txstart", 32'(bus.tx_start),  32'd0);
      chk("t6_txbyte",  32'(bus.tx_byte),   32'h00);
      chk("t6_errcode", 32'(bus.err_code),  32'd0);
      cyc();
      rst = 1'b0;
      pulse_txd();
      repeat (3) cyc();
      chk("t6_ready2", 32'(bus.req_ready), 32'd1);
      chk("t6_ndone",  n_done - b_done, 0);
      chk("t6_nerr",   n_err - b_err, 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_chk);
      $finish;
   end

endmodule
